// File: rtl/iob_cfg_loader.sv
// ----------------------------------------------------------------------------
// iob_cfg_loader
//   Loads one IOB configuration word into the serial-in/parallel-out IOB
//   configuration chain. A parallel word is taken over a valid/ready
//   handshake, shifted out LSB-first (one SH_EN_IOB strobe every SHIFT_DIV
//   clocks), and then committed with a single UPD_IOB strobe.
//
// Parameters
//   WIDTH       configuration word / chain length in bits (>= 2)
//   SHIFT_DIV   clocks per shifted bit (>= 1)
//
// Ports
//   CLOCK_IOB    in   clock, rising edge
//   RES_IOB      in   synchronous active-high reset
//   CFG_DAT_IOB  in   configuration word, sampled on accept only
//   CFG_VLD_IOB  in   word valid
//   CFG_RDY_IOB  out  loader idle and able to accept a word
//   ABORT_IOB    in   cancel an in-progress load (ignored when idle)
//   SH_EN_IOB    out  shift-enable strobe to the chain, one per bit
//   SH_DAT_IOB   out  serial data to the chain, 0 when SH_EN_IOB is low
//   UPD_IOB      out  one-cycle commit strobe after the last bit
//   BUSY_IOB     out  load in progress (SHIFT or LATCH)
//   DONE_IOB     out  one-cycle pulse: load shifted and committed
//   ABT_IOB      out  one-cycle pulse: load was aborted
// ----------------------------------------------------------------------------
module iob_cfg_loader #(
  parameter int WIDTH     = 112,
  parameter int SHIFT_DIV = 1
) (
  input  logic             CLOCK_IOB,
  input  logic             RES_IOB,
  input  logic [WIDTH-1:0] CFG_DAT_IOB,
  input  logic             CFG_VLD_IOB,
  output logic             CFG_RDY_IOB,
  input  logic             ABORT_IOB,
  output logic             SH_EN_IOB,
  output logic             SH_DAT_IOB,
  output logic             UPD_IOB,
  output logic             BUSY_IOB,
  output logic             DONE_IOB,
  output logic             ABT_IOB
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shadow_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [DW-1:0]    div_cnt_q;
  logic             done_q;
  logic             abt_q;

  logic div_wrap;
  logic strobe;

  assign div_wrap = (div_cnt_q == DIV_LAST);
  // An abort in the same cycle suppresses the strobe, so the chain never
  // sees a bit the loader is about to abandon.
  assign strobe   = (state_q == SHIFT) && div_wrap && !ABORT_IOB;

  assign CFG_RDY_IOB = (state_q == IDLE);
  assign BUSY_IOB    = (state_q != IDLE);
  assign SH_EN_IOB   = strobe;
  assign SH_DAT_IOB  = strobe & shadow_q[0];
  assign UPD_IOB     = (state_q == LATCH) && !ABORT_IOB;
  assign DONE_IOB    = done_q;
  assign ABT_IOB     = abt_q;

  // NOTE: every register below is assigned with <= so all of them update
  // together from the values seen before the edge; a blocking = here would
  // let later statements observe half-updated state.
  always_ff @(posedge CLOCK_IOB) begin
    if (RES_IOB) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
      abt_q     <= 1'b0;
    end else begin
      // Completion / abort flags are single-cycle pulses by default.
      done_q <= 1'b0;
      abt_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (CFG_VLD_IOB) begin
            shadow_q  <= CFG_DAT_IOB;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (ABORT_IOB) begin
            state_q <= IDLE;
            abt_q   <= 1'b1;
          end else begin
            div_cnt_q <= div_wrap ? '0 : div_cnt_q + DW'(1);
            if (div_wrap) begin
              shadow_q  <= shadow_q >> 1;
              bit_cnt_q <= bit_cnt_q + BW'(1);
              if (bit_cnt_q == BIT_LAST) begin
                state_q <= LATCH;
              end
            end
          end
        end
        LATCH: begin
          state_q <= IDLE;
          if (ABORT_IOB) begin
            abt_q <= 1'b1;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
